// File: rtl/mult_seq_8bits.sv
// Sequential 8x8 unsigned shift-and-add multiplier around the SomComp8bits ripple-carry adder.
// Optional build macro MULT_SEQ_ZERO_SKIP_EN: zero operands bypass CALC and finish in one cycle.

module SomComp8bits (
  output logic [7:0] S,
  output logic       Cout,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin
);
  logic [8:0] carry;

  always_comb begin
    carry[0] = Cin;
    S        = '0;
    for (int i = 0; i < 8; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = carry[8];
endmodule

// state | meaning
// IDLE  | waiting for start; P holds last product
// CALC  | eight add/shift iterations, busy=1
// DONE  | one-cycle done pulse, P just updated; start here chains the next operation
module mult_seq_8bits (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;

  logic [7:0]  sum;
  logic        cout;
  logic [7:0]  acc_add;
  logic        c_add;
  logic        load;

  SomComp8bits u_add (
    .S    (sum),
    .Cout (cout),
    .A    (acc_q),
    .B    (m_q),
    .Cin  (1'b0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    acc_add = acc_q;
    c_add   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load = start;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (q_q[0]) begin
          acc_add = sum;
          c_add   = cout;
        end
        // Shift uses the post-add carry/accumulator so add and shift share one edge.
        {c_d, acc_d, q_d} = {c_add, acc_add, q_q} >> 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          p_d     = {acc_d, q_d};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        load    = start;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      m_d     = A;
      q_d     = B;
      acc_d   = '0;
      c_d     = 1'b0;
      cnt_d   = '0;
      state_d = ST_CALC;
`ifdef MULT_SEQ_ZERO_SKIP_EN
      if ((A == 8'd0) || (B == 8'd0)) begin
        p_d     = '0;
        state_d = ST_DONE;
      end
`else
`endif
    end
  end

  assign P = p_q;
endmodule

// File: tb/tb_mult_seq_8bits.sv
// Bench for mult_seq_8bits: cycle-level product/latency model plus directed literal checks.
module tb_mult_seq_8bits;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] P;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mult_seq_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  // Model: an accepted request yields A*B after 8 busy cycles (or at once for a zero
  // operand in the skip build); requests are ignored while a product is in flight.
  int          m_left = 0;
  logic [15:0] m_p = '0;
  logic [15:0] m_pend = '0;
  bit          m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_p    = '0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) m_p = m_pend;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = 16'(A) * 16'(B);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        if (A == 8'd0 || B == 8'd0) begin
          m_done = 1'b1;
          m_p    = '0;
        end else begin
          m_left = 8;
        end
`else
        m_left = 8;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (P !== m_p || busy !== (m_left > 0) || done !== m_done) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t P=%h req %h busy=%b req %b done=%b req %b",
                 $time, P, m_p, busy, (m_left > 0), done, m_done);
      end
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap t=%0t busy=%b done=%b required not both 1", $time, busy, done);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #2;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (busy) busy_n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bn, ndone;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #20;
    chk("reset_P", 32'(P), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    pulse(8'd5, 8'd3);
    wait_done(cyc, bn);
    chk("5x3_latency", cyc, 9);
    chk("5x3_busy_cycles", bn, 8);
    chk("5x3_P", 32'(P), 15);
    repeat (3) @(negedge clk);
    chk("5x3_P_hold", 32'(P), 15);
    chk("5x3_idle_busy", 32'(busy), 0);

    pulse(8'd255, 8'd255);
    wait_done(cyc, bn);
    chk("255x255_P", 32'(P), 32'hFE01);
    chk("255x255_latency", cyc, 9);

    pulse(8'd7, 8'd9);
    repeat (2) @(negedge clk);
    pulse(8'd1, 8'd1);
    wait_done(cyc, bn);
    chk("ignore_start_P", 32'(P), 63);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignore_start_extra_done", ndone, 0);

    pulse(8'd200, 8'd100);
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midcalc_rst_P", 32'(P), 0);
    chk("midcalc_rst_busy", 32'(busy), 0);
    chk("midcalc_rst_done", 32'(done), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 0);
    pulse(8'd200, 8'd100);
    wait_done(cyc, bn);
    chk("200x100_P", 32'(P), 20000);
    chk("200x100_latency", cyc, 9);

    @(posedge clk); #2;
    A = 8'd16; B = 8'd16; start = 1'b1;
    wait_done(cyc, bn);
    chk("held_first_latency", cyc, 10);
    chk("held_first_P", 32'(P), 256);
    chk("held_first_busy", 32'(busy), 0);
    for (int i = 0; i < 2; i++) begin
      wait_done(cyc, bn);
      chk("held_period", cyc, 9);
      chk("held_P", 32'(P), 256);
      chk("held_done_busy", 32'(busy), 0);
    end
    @(posedge clk); #2 start = 1'b0;
    wait_done(cyc, bn);
    chk("held_tail_latency", cyc, 9);
    chk("held_tail_P", 32'(P), 256);

    pulse(8'd0, 8'd77);
    wait_done(cyc, bn);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    chk("zero_latency", cyc, 1);
    chk("zero_busy_cycles", bn, 0);
`else
    chk("zero_latency", cyc, 9);
    chk("zero_busy_cycles", bn, 8);
`endif
    chk("zero_P", 32'(P), 0);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
